spi_slv16: RTL and testbench

16-bit SPI responder: the device-side end of the team's 16-bit SPI master link. It sits on the peripheral side of the bus, clocked by its own system clock. It oversamples SS_n, SCLK and MOSI, shifts a 16-bit word in on MOSI while shifting a preloaded 16-bit response out on MISO, and presents the received word to local logic with a one-cycle valid pulse.

---
 rtl/spi_slv16_if.sv | 24 ++
 rtl/spi_slv16.sv | 131 +++++++++++++
 tb/tb_spi_slv16.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/spi_slv16_if.sv
// Bus-side signal bundle for the spi_slv16 responder: SPI pins plus the
// local word-transfer handshake. The slave modport is the responder's view.
interface spi_slv16_if;
   logic        SS_n;
   logic        SCLK;
   logic        MOSI;
   logic        MISO;
   logic        wrt;
   logic [15:0] tx_data;
   logic [15:0] rx_data;
   logic        rdy;
   logic        frame_err;
   logic        busy;

   modport slave (
      input  SS_n, SCLK, MOSI, wrt, tx_data,
      output MISO, rx_data, rdy, frame_err, busy
   );

   modport master (
      output SS_n, SCLK, MOSI, wrt, tx_data,
      input  MISO, rx_data, rdy, frame_err, busy
   );
endinterface

// File: rtl/spi_slv16.sv
// spi_slv16: 16-bit SPI responder (CPOL=1, CPHA=1, MSB first).
// Oversamples SS_n/SCLK/MOSI on clk, shifts a word in on MOSI while shifting
// the preloaded response out on MISO, and pulses rdy / frame_err at frame end.
// Optional feature macro: SPI_SLV_MISO_TRI_EN -- MISO floats (1'bz) while idle.
module spi_slv16 (
   input  logic        clk,
   input  logic        rst,
   spi_slv16_if.slave  bus
);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t      state_q, state_d;
   logic [2:0]  ss_q;
   logic [2:0]  sclk_q;
   logic [1:0]  mosi_q;
   logic [15:0] shft_q, shft_d;
   logic [15:0] tx_buf_q, tx_buf_d;
   logic [15:0] rx_data_q, rx_data_d;
   logic [4:0]  bit_cnt_q, bit_cnt_d;
   logic        ovr_q, ovr_d;
   logic        miso_q, miso_d;
   logic        rdy_q, rdy_d;
   logic        ferr_q, ferr_d;

   logic ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_s;

   // Two-flop synchronisers plus a third edge-detect flop on SS_n and SCLK.
   // SS_n chain resets low so that SS_n held low across reset release is not
   // mistaken for a falling edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ss_q   <= '0;
         sclk_q <= '1;
         mosi_q <= '0;
      end else begin
         ss_q   <= {ss_q[1:0], bus.SS_n};
         sclk_q <= {sclk_q[1:0], bus.SCLK};
         mosi_q <= {mosi_q[0], bus.MOSI};
      end
   end

   assign ss_fall   =  ss_q[2]   & ~ss_q[1];
   assign ss_rise   = ~ss_q[2]   &  ss_q[1];
   assign sclk_rise = ~sclk_q[2] &  sclk_q[1];
   assign sclk_fall =  sclk_q[2] & ~sclk_q[1];
   assign mosi_s    =  mosi_q[1];

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         shft_q    <= '0;
         tx_buf_q  <= '0;
         rx_data_q <= '0;
         bit_cnt_q <= '0;
         ovr_q     <= 1'b0;
         miso_q    <= 1'b0;
         rdy_q     <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shft_q    <= shft_d;
         tx_buf_q  <= tx_buf_d;
         rx_data_q <= rx_data_d;
         bit_cnt_q <= bit_cnt_d;
         ovr_q     <= ovr_d;
         miso_q    <= miso_d;
         rdy_q     <= rdy_d;
         ferr_q    <= ferr_d;
      end
   end

   // Next-state logic; an SS_n rise in SHIFT takes priority over SCLK edges.
   always_comb begin
      state_d   = state_q;
      shft_d    = shft_q;
      tx_buf_d  = bus.wrt ? bus.tx_data : tx_buf_q;
      rx_data_d = rx_data_q;
      bit_cnt_d = bit_cnt_q;
      ovr_d     = ovr_q;
      miso_d    = miso_q;
      rdy_d     = 1'b0;
      ferr_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (ss_fall) begin
               state_d   = SHIFT;
               shft_d    = tx_buf_q;
               bit_cnt_d = '0;
               miso_d    = tx_buf_q[15];
            end
         end
         SHIFT: begin
            if (ss_rise) begin
               state_d = IDLE;
               if ((bit_cnt_q == 5'd16) && !ovr_q) begin
                  rx_data_d = shft_q;
                  rdy_d     = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
               ovr_d = 1'b0;
            end else if (sclk_rise) begin
               if (bit_cnt_q < 5'd16) begin
                  shft_d    = {shft_q[14:0], mosi_s};
                  bit_cnt_d = bit_cnt_q + 5'd1;
               end else begin
                  ovr_d = 1'b1;
               end
            end else if (sclk_fall) begin
               miso_d = shft_q[15];
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.rx_data   = rx_data_q;
   assign bus.rdy       = rdy_q;
   assign bus.frame_err = ferr_q;
   assign bus.busy      = (state_q == SHIFT);

`ifdef SPI_SLV_MISO_TRI_EN
   assign bus.MISO = (state_q == SHIFT) ? miso_q : 1'bz;
`else
   assign bus.MISO = miso_q;
`endif

endmodule

// File: tb/tb_spi_slv16.sv
// Scoreboard bench for spi_slv16: the master drives directed frames and
// queues the expected end-of-frame event; a monitor pops on rdy/frame_err.
module tb_spi_slv16;

   logic clk;
   logic rst;
   spi_slv16_if bus_if ();

   spi_slv16 dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          err;
      logic [15:0] rx;
      bit          chk_miso;
      logic [15:0] miso;
   } exp_t;

   exp_t        sb_q[$];
   int          checks   = 0;
   int          failures = 0;
   logic [15:0] miso_rd;
   logic        rdy_prev;
   logic        ferr_prev;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic write_tx(input logic [15:0] v);
      bus_if.tx_data = v;
      bus_if.wrt     = 1'b1;
      tick(1);
      bus_if.wrt     = 1'b0;
      tick(1);
   endtask

   // One SCLK cycle: fall (drive MOSI), hold, sample MISO, rise, hold.
   task automatic sclk_bit(input logic b, input bit do_wr, input logic [15:0] wr_val);
      bus_if.SCLK = 1'b0;
      bus_if.MOSI = b;
      if (do_wr) write_tx(wr_val);
      else tick(2);
      tick(4);
      miso_rd     = {miso_rd[14:0], bus_if.MISO};
      bus_if.SCLK = 1'b1;
      tick(6);
   endtask

   task automatic frame(input logic [15:0] mosi_w, input int nbits, input logic extra,
                        input int wr_at, input logic [15:0] wr_val);
      logic b;
      miso_rd     = '0;
      bus_if.SS_n = 1'b0;
      tick(6);
      chk("busy_in_frame", {31'b0, bus_if.busy}, 32'd1);
      for (int i = 0; i < nbits; i++) begin
         b = (i < 16) ? mosi_w[15 - i] : extra;
         sclk_bit(b, (i == wr_at), wr_val);
      end
      tick(2);
      bus_if.SS_n = 1'b1;
      tick(10);
      chk("busy_after_frame", {31'b0, bus_if.busy}, 32'd0);
   endtask

   task automatic push_exp(input bit err, input logic [15:0] rx, input bit cm, input logic [15:0] m);
      exp_t e;
      e.err = err; e.rx = rx; e.chk_miso = cm; e.miso = m;
      sb_q.push_back(e);
   endtask

   task automatic chk_idle_miso(input string name);
`ifdef SPI_SLV_MISO_TRI_EN
      chk(name, {31'b0, bus_if.MISO}, {31'b0, 1'bz});
`else
      checks++;
      if (bus_if.MISO === 1'bz || bus_if.MISO === 1'bx) begin
         failures++;
         $display("FAIL %s: got %b expected driven 0/1", name, bus_if.MISO);
      end
`endif
   endtask

   // Monitor: every rdy / frame_err pulse must match the head of the queue.
   always @(negedge clk) begin
      if (rst) begin
         rdy_prev  <= 1'b0;
         ferr_prev <= 1'b0;
      end else begin
         if (bus_if.rdy && rdy_prev)       chk("rdy_width", 32'd2, 32'd1);
         if (bus_if.frame_err && ferr_prev) chk("ferr_width", 32'd2, 32'd1);
         if ((bus_if.rdy && !rdy_prev) || (bus_if.frame_err && !ferr_prev)) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_pulse", {30'b0, bus_if.rdy, bus_if.frame_err}, 32'd0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               chk("pulse_kind", {30'b0, bus_if.rdy, bus_if.frame_err},
                   e.err ? 32'd1 : 32'd2);
               chk("rx_data", {16'b0, bus_if.rx_data}, {16'b0, e.rx});
               if (e.chk_miso) chk("miso_word", {16'b0, miso_rd}, {16'b0, e.miso});
            end
         end
         rdy_prev  <= bus_if.rdy;
         ferr_prev <= bus_if.frame_err;
      end
   end

   initial begin
      rst            = 1'b1;
      bus_if.SS_n    = 1'b1;
      bus_if.SCLK    = 1'b1;
      bus_if.MOSI    = 1'b0;
      bus_if.wrt     = 1'b0;
      bus_if.tx_data = '0;
      tick(3);
      chk("rst_rx_data", {16'b0, bus_if.rx_data}, 32'd0);
      chk("rst_rdy",     {31'b0, bus_if.rdy},       32'd0);
      chk("rst_ferr",    {31'b0, bus_if.frame_err}, 32'd0);
      chk("rst_busy",    {31'b0, bus_if.busy},      32'd0);
`ifndef SPI_SLV_MISO_TRI_EN
      chk("rst_miso",    {31'b0, bus_if.MISO},      32'd0);
`endif
      tick(2);
      rst = 1'b0;
      tick(5);
      chk_idle_miso("idle_miso_0");

      // Basic frame
      write_tx(16'hA5C3);
      push_exp(1'b0, 16'h1234, 1'b1, 16'hA5C3);
      frame(16'h1234, 16, 1'b0, -1, 16'h0);
      chk_idle_miso("idle_miso_1");

      // Back-to-back, with a write during frame 1
      push_exp(1'b0, 16'h0F0F, 1'b1, 16'hA5C3);
      frame(16'h0F0F, 16, 1'b0, 8, 16'h00FF);
      push_exp(1'b0, 16'hF00D, 1'b1, 16'h00FF);
      frame(16'hF00D, 16, 1'b0, -1, 16'h0);

      // Short frame: 9 clocks
      push_exp(1'b1, 16'hF00D, 1'b0, 16'h0);
      frame(16'h1357, 9, 1'b0, -1, 16'h0);

      // Long frame: 17 clocks, then a good frame
      push_exp(1'b1, 16'hF00D, 1'b0, 16'h0);
      frame(16'hBEEF, 17, 1'b1, -1, 16'h0);
      push_exp(1'b0, 16'hCAFE, 1'b1, 16'h00FF);
      frame(16'hCAFE, 16, 1'b0, -1, 16'h0);

      // Reset mid-frame
      write_tx(16'h1111);
      bus_if.SS_n = 1'b0;
      tick(6);
      for (int i = 0; i < 8; i++) sclk_bit(i[0], 1'b0, 16'h0);
      rst = 1'b1;
      #2;
      chk("mid_rst_rx_data", {16'b0, bus_if.rx_data}, 32'd0);
      chk("mid_rst_busy",    {31'b0, bus_if.busy},    32'd0);
      chk("mid_rst_rdy",     {31'b0, bus_if.rdy},     32'd0);
      chk("mid_rst_ferr",    {31'b0, bus_if.frame_err}, 32'd0);
      tick(3);
      rst = 1'b0;
      tick(4);
      chk("post_rst_idle", {31'b0, bus_if.busy}, 32'd0);
      bus_if.SS_n = 1'b1;
      tick(10);
      push_exp(1'b0, 16'h5A5A, 1'b1, 16'h0000);
      frame(16'h5A5A, 16, 1'b0, -1, 16'h0);
      chk_idle_miso("idle_miso_2");

      tick(20);
      chk("sb_empty", sb_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
